belt_transfer_controller: RTL

//  Actuator end of belt balancing: consumes signal_A/signal_B requests from the balancer and

---
 rtl/balance_pkg.sv | 22 ++
 rtl/tick_timer.sv | 34 +++
 rtl/belt_transfer_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/balance_pkg.sv
// rtl/balance_pkg.sv - shared types, saturation limits and count helper for belt balancing
package balance_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MOVE, COOLDOWN} state_t;
  typedef enum logic {DIR_0TO1, DIR_1TO0} dir_t;

  // Symmetric range so the net count can always be negated without overflow.
  localparam logic signed [31:0] COUNT_MAX = 32'sd2147483647;
  localparam logic signed [31:0] COUNT_MIN = -32'sd2147483647;

  function automatic logic signed [31:0] sat_step(input logic signed [31:0] cnt, input dir_t dir);
    logic signed [31:0] nxt;
    nxt = cnt;
    if (dir == DIR_0TO1) begin
      if (cnt != COUNT_MAX) nxt = cnt + 32'sd1;
    end else begin
      if (cnt != COUNT_MIN) nxt = cnt - 32'sd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable down-counter with a zero flag; load takes priority over dec
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/belt_transfer_controller.sv
// rtl/belt_transfer_controller.sv - debounced, burst-limited cross-belt inserter control
module belt_transfer_controller #(
  parameter int DWELL_TICKS    = 8,
  parameter int BURST_MAX      = 16,
  parameter int TIMEOUT_TICKS  = 60,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        signal_A,
  input  logic        signal_B,
  input  logic        item_moved,
  output logic        inserter_0to1,
  output logic        inserter_1to0,
  output logic        busy,
  output logic        conflict,
  output logic        stall,
  output logic [31:0] transfer_count
);
  import balance_pkg::*;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d, req_dir;
  logic [15:0]        burst_q, burst_d;
  logic signed [31:0] count_q, count_d;
  logic               stall_q, stall_d, conflict_q, conflict_d, busy_q, busy_d;
  logic               ins01_q, ins01_d, ins10_q, ins10_d;
  logic               req, req_ok, expire;
  logic               dwell_load, dwell_dec, dwell_zero;
  logic               tmo_load, tmo_dec, tmo_zero;
  logic               cool_load, cool_dec, cool_zero;

  tick_timer #(.WIDTH(16)) u_dwell (
    .clk(clk), .rst(rst), .load(dwell_load), .load_val(16'(DWELL_TICKS - 1)),
    .dec(dwell_dec), .zero(dwell_zero)
  );

  tick_timer #(.WIDTH(16)) u_timeout (
    .clk(clk), .rst(rst), .load(tmo_load), .load_val(16'(TIMEOUT_TICKS - 1)),
    .dec(tmo_dec), .zero(tmo_zero)
  );

  tick_timer #(.WIDTH(16)) u_cooldown (
    .clk(clk), .rst(rst), .load(cool_load), .load_val(16'(COOLDOWN_TICKS - 1)),
    .dec(cool_dec), .zero(cool_zero)
  );

  always_comb begin
    req        = enable && (signal_A ^ signal_B);
    req_dir    = signal_A ? DIR_0TO1 : DIR_1TO0;
    req_ok     = req && (req_dir == dir_q);
    expire     = tmo_zero && !item_moved;
    state_d    = state_q;
    dir_d      = dir_q;
    burst_d    = burst_q;
    count_d    = count_q;
    stall_d    = stall_q;
    dwell_load = 1'b0;
    dwell_dec  = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    cool_load  = 1'b0;
    cool_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = ARM;
          dir_d      = req_dir;
          dwell_load = 1'b1;
        end
      end
      ARM: begin
        if (!req_ok) begin
          state_d = IDLE;
        end else if (dwell_zero) begin
          state_d  = MOVE;
          burst_d  = '0;
          tmo_load = 1'b1;
        end else begin
          dwell_dec = 1'b1;
        end
      end
      MOVE: begin
        tmo_dec = 1'b1;
        if (item_moved) begin
          burst_d  = burst_q + 16'd1;
          count_d  = sat_step(count_q, dir_q);
          stall_d  = 1'b0;
          tmo_load = 1'b1;
        end
        // The same-cycle item is already counted above before deciding to leave.
        if ((item_moved && (burst_d == 16'(BURST_MAX))) || !req_ok || expire) begin
          state_d   = COOLDOWN;
          cool_load = 1'b1;
          if (expire) stall_d = 1'b1;
        end
      end
      COOLDOWN: begin
        if (item_moved) count_d = sat_step(count_q, dir_q);
        if (cool_zero) begin
          state_d = IDLE;
        end else begin
          cool_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    ins01_d    = (state_d == MOVE) && (dir_d == DIR_0TO1);
    ins10_d    = (state_d == MOVE) && (dir_d == DIR_1TO0);
    conflict_d = signal_A && signal_B && ((state_q == IDLE) || (state_q == ARM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= DIR_0TO1;
      burst_q    <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
      ins01_q    <= 1'b0;
      ins10_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      burst_q    <= burst_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      conflict_q <= conflict_d;
      busy_q     <= busy_d;
      ins01_q    <= ins01_d;
      ins10_q    <= ins10_d;
    end
  end

  assign inserter_0to1  = ins01_q;
  assign inserter_1to0  = ins10_q;
  assign busy           = busy_q;
  assign conflict       = conflict_q;
  assign stall          = stall_q;
  assign transfer_count = count_q;

endmodule
